// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing per-stage stall/flush,
// exception redirect, divider abort and a saturating stalled-cycle counter.
`default_nettype none

module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_rmem_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        dreq_i,
  input  logic        dack_i,
  input  logic        ifetch_busy_i,
  input  logic        exc_i,
  input  logic        cnt_clr_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        redirect_o,
  output logic        div_abort_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DIV_WAIT = 2'd2;
  localparam logic [1:0] EXC      = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] stall_cnt;
  logic        load_use;
  logic        mem_stall;

  assign load_use  = ex_rmem_i && (ex_waddr_i != 5'd0) &&
                     ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));
  assign mem_stall = dreq_i && !dack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (exc_i)            state_nxt = EXC;
        else if (mem_stall)   state_nxt = MEM_WAIT;
        else if (div_start_i) state_nxt = DIV_WAIT;
        else                  state_nxt = RUN;
      end
      MEM_WAIT: begin
        if (dack_i) state_nxt = RUN;
      end
      DIV_WAIT: begin
        if (exc_i)           state_nxt = EXC;
        else if (div_done_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Reset dominates combinationally so the flush pattern appears without waiting for a clock.
  always_comb begin
    stall_o     = 5'b00000;
    flush_o     = 5'b00000;
    redirect_o  = 1'b0;
    div_abort_o = 1'b0;
    if (rst_i) begin
      flush_o = 5'b11111;
    end else begin
      case (state)
        RUN: begin
          if (exc_i) begin
            flush_o = 5'b11110;
          end else if (mem_stall) begin
            stall_o = 5'b01111;
            flush_o = 5'b10000;
          end else if (div_start_i) begin
            stall_o = 5'b00111;
            flush_o = 5'b01000;
          end else if (load_use) begin
            stall_o = 5'b00011;
            flush_o = 5'b00100;
          end else if (ifetch_busy_i) begin
            stall_o = 5'b00001;
            flush_o = 5'b00010;
          end
        end
        MEM_WAIT: begin
          if (!dack_i) begin
            stall_o = 5'b01111;
            flush_o = 5'b10000;
          end
        end
        DIV_WAIT: begin
          if (exc_i) begin
            flush_o     = 5'b11110;
            div_abort_o = 1'b1;
          end else if (!div_done_i) begin
            stall_o = 5'b00111;
            flush_o = 5'b01000;
          end
        end
        default: begin
          redirect_o = 1'b1;
          flush_o    = 5'b00010;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= 32'd0;
    end else if (cnt_clr_i) begin
      stall_cnt <= 32'd0;
    end else if ((stall_o != 5'b00000) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a scoreboard queue of hand-computed
// expectations, checked by an independent monitor between clock edges.
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, ex_waddr = 5'd0;
  logic        ex_rmem = 1'b0, div_start = 1'b0, div_done = 1'b0;
  logic        dreq = 1'b0, dack = 1'b0, ifetch_busy = 1'b0, exc = 1'b0, cnt_clr = 1'b0;
  logic [4:0]  stall, flush;
  logic        redirect, div_abort;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  pipe_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_rmem_i(ex_rmem), .ex_waddr_i(ex_waddr),
    .div_start_i(div_start), .div_done_i(div_done),
    .dreq_i(dreq), .dack_i(dack),
    .ifetch_busy_i(ifetch_busy), .exc_i(exc), .cnt_clr_i(cnt_clr),
    .stall_o(stall), .flush_o(flush),
    .redirect_o(redirect), .div_abort_o(div_abort),
    .state_o(state), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect;
    logic        abort;
    logic [1:0]  state;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_waddr = 5'd0; ex_rmem = 1'b0;
    div_start = 1'b0; div_done = 1'b0; dreq = 1'b0; dack = 1'b0;
    ifetch_busy = 1'b0; exc = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [4:0] s, input logic [4:0] f,
                            input logic r, input logic a, input logic [1:0] st,
                            input logic [31:0] c);
    exp_t e;
    e.name = name; e.stall = s; e.flush = f; e.redirect = r;
    e.abort = a; e.state = st; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs settle after the negedge drive, sampled well before the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (stall !== e.stall || flush !== e.flush || redirect !== e.redirect ||
            div_abort !== e.abort || state !== e.state || stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got stall=%b flush=%b redir=%b abort=%b state=%0d cnt=%h, want stall=%b flush=%b redir=%b abort=%b state=%0d cnt=%h",
                   e.name, stall, flush, redirect, div_abort, state, stall_cnt,
                   e.stall, e.flush, e.redirect, e.abort, e.state, e.cnt);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    @(negedge clk); idle(); rst = 1'b1;
    expect_out("reset", 5'b00000, 5'b11111, 0, 0, 2'd0, 32'd0);
    @(negedge clk); rst = 1'b0; idle();
    expect_out("idle", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd0);

    // load-use hazards
    @(negedge clk); idle(); ex_rmem = 1; ex_waddr = 5'd5; id_rt = 5'd5;
    expect_out("lu_rt", 5'b00011, 5'b00100, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle(); ex_rmem = 1; ex_waddr = 5'd0; id_rt = 5'd0;
    expect_out("lu_r0", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd1);
    @(negedge clk); idle(); ex_rmem = 1; ex_waddr = 5'd7; id_rs = 5'd7;
    expect_out("lu_rs", 5'b00011, 5'b00100, 0, 0, 2'd0, 32'd1);
    @(negedge clk); idle(); ifetch_busy = 1;
    expect_out("ifetch", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'd2);
    @(negedge clk); idle(); ifetch_busy = 1; ex_rmem = 1; ex_waddr = 5'd5; id_rt = 5'd5;
    expect_out("lu_over_if", 5'b00011, 5'b00100, 0, 0, 2'd0, 32'd3);
    @(negedge clk); idle(); cnt_clr = 1;
    expect_out("clr_idle", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd4);

    // memory wait, exception ignored while waiting
    @(negedge clk); idle(); dreq = 1;
    expect_out("mem_start", 5'b01111, 5'b10000, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle(); dreq = 1; exc = 1;
    expect_out("mem_wait_exc", 5'b01111, 5'b10000, 0, 0, 2'd1, 32'd1);
    @(negedge clk); idle(); dreq = 1;
    expect_out("mem_wait", 5'b01111, 5'b10000, 0, 0, 2'd1, 32'd2);
    @(negedge clk); idle(); dreq = 1; dack = 1;
    expect_out("mem_ack", 5'b00000, 5'b00000, 0, 0, 2'd1, 32'd3);
    @(negedge clk); idle(); cnt_clr = 1;
    expect_out("mem_cnt3", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd3);

    // divide aborted by exception (exc beats div_done)
    @(negedge clk); idle(); div_start = 1;
    expect_out("div_start", 5'b00111, 5'b01000, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle();
    expect_out("div_wait", 5'b00111, 5'b01000, 0, 0, 2'd2, 32'd1);
    @(negedge clk); idle(); exc = 1; div_done = 1;
    expect_out("div_abort", 5'b00000, 5'b11110, 0, 1, 2'd2, 32'd2);
    @(negedge clk); idle(); exc = 1; dreq = 1;
    expect_out("exc_redirect", 5'b00000, 5'b00010, 1, 0, 2'd3, 32'd2);
    @(negedge clk); idle();
    expect_out("exc_back_run", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd2);

    // divide completes
    @(negedge clk); idle(); div_start = 1;
    expect_out("div2_start", 5'b00111, 5'b01000, 0, 0, 2'd0, 32'd2);
    @(negedge clk); idle(); div_done = 1;
    expect_out("div2_done", 5'b00000, 5'b00000, 0, 0, 2'd2, 32'd3);
    @(negedge clk); idle();
    expect_out("div2_run", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd3);

    // priority
    @(negedge clk); idle(); exc = 1; dreq = 1; div_start = 1;
    ex_rmem = 1; ex_waddr = 5'd3; id_rs = 5'd3; ifetch_busy = 1;
    expect_out("prio_exc", 5'b00000, 5'b11110, 0, 0, 2'd0, 32'd3);
    @(negedge clk); idle();
    expect_out("prio_exc_st", 5'b00000, 5'b00010, 1, 0, 2'd3, 32'd3);
    @(negedge clk); idle(); dreq = 1; div_start = 1;
    expect_out("prio_mem", 5'b01111, 5'b10000, 0, 0, 2'd0, 32'd3);
    @(negedge clk); idle(); dreq = 1; dack = 1;
    expect_out("prio_mem_ack", 5'b00000, 5'b00000, 0, 0, 2'd1, 32'd4);
    @(negedge clk); idle(); dreq = 1; dack = 1;
    expect_out("run_acked_req", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd4);

    // counter saturation and clear priority
    @(negedge clk); idle(); ifetch_busy = 1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    expect_out("cnt_fffe", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'hFFFF_FFFE);
    @(negedge clk); idle(); ifetch_busy = 1;
    expect_out("cnt_ffff", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'hFFFF_FFFF);
    @(negedge clk); idle(); ifetch_busy = 1;
    expect_out("cnt_sat", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'hFFFF_FFFF);
    @(negedge clk); idle(); ifetch_busy = 1; cnt_clr = 1;
    expect_out("cnt_clr_stall", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'hFFFF_FFFF);
    @(negedge clk); idle();
    expect_out("cnt_zero", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd0);

    // asynchronous reset while waiting on the divider
    @(negedge clk); idle(); div_start = 1;
    expect_out("div3_start", 5'b00111, 5'b01000, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle();
    expect_out("div3_wait", 5'b00111, 5'b01000, 0, 0, 2'd2, 32'd1);
    @(negedge clk); idle(); exc = 1; rst = 1'b1;
    expect_out("async_rst", 5'b00000, 5'b11111, 0, 0, 2'd0, 32'd0);
    @(negedge clk); rst = 1'b0; idle();
    expect_out("post_rst", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle(); ifetch_busy = 1;
    expect_out("post_rst_if", 5'b00001, 5'b00010, 0, 0, 2'd0, 32'd0);
    @(negedge clk); idle();
    expect_out("post_rst_cnt", 5'b00000, 5'b00000, 0, 0, 2'd0, 32'd1);

    @(negedge clk); idle();
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports id_rs_i, id_rt_i  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports ex_rmem_i  in  1, ex_waddr_i  in  5  load-in-EX flag and its destination register.
REQ-005 SHALL have ports div_start_i  in  1  divide issued in EX; div_done_i  in  1  divider result valid.
REQ-006 SHALL have ports dreq_i  in  1  MEM-stage data access; dack_i  in  1  data bus acknowledge.
REQ-007 SHALL have port ifetch_busy_i  in  1  instruction fetch not yet returned.
REQ-008 SHALL have port exc_i  in  1  exception committed in MEM.
REQ-009 SHALL have port cnt_clr_i  in  1  synchronous clear of the stall counter.
REQ-010 SHALL have ports stall_o  out  5 and flush_o  out  5, with bit [0]=pc, [1]=if2id, [2]=id2exe, [3]=exe2mem, [4]=mem2wb.
REQ-011 SHALL have ports redirect_o  out  1  PC loads exception vector; div_abort_o  out  1  cancel divider.
REQ-012 SHALL have ports state_o  out  2  current state; stall_cnt_o  out  32  stalled-cycle count.

Function
REQ-013 SHALL implement states RUN=0, MEM_WAIT=1, DIV_WAIT=2, EXC=3; stall_o, flush_o, redirect_o and div_abort_o are combinational from the state and inputs.
REQ-014 In RUN, SHALL evaluate causes in this priority: exc_i, then (dreq_i && !dack_i), then div_start_i, then load-use, then ifetch_busy_i; only the highest active cause acts.
REQ-015 RUN with exc_i: flush_o=5'b11110, stall_o=0, next state EXC.
REQ-016 RUN with dreq_i && !dack_i: stall_o=5'b01111, flush_o=5'b10000, next state MEM_WAIT.
REQ-017 RUN with div_start_i: stall_o=5'b00111, flush_o=5'b01000, next state DIV_WAIT.
REQ-018 Load-use is defined as ex_rmem_i && ex_waddr_i!=0 && (ex_waddr_i==id_rs_i || ex_waddr_i==id_rt_i); it SHALL give stall_o=5'b00011, flush_o=5'b00100, and the state stays RUN.
REQ-019 RUN with ifetch_busy_i only: stall_o=5'b00001, flush_o=5'b00010, and the state stays RUN.
REQ-020 RUN with no cause: stall_o=0, flush_o=0.
REQ-021 MEM_WAIT with !dack_i: stall_o=5'b01111, flush_o=5'b10000; exc_i SHALL be ignored.
REQ-022 MEM_WAIT with dack_i: stall_o=0, flush_o=0 in the same cycle; next state RUN.
REQ-023 DIV_WAIT with exc_i: flush_o=5'b11110, div_abort_o=1 for that cycle only, next state EXC; this takes priority over div_done_i.
REQ-024 DIV_WAIT with !div_done_i: stall_o=5'b00111, flush_o=5'b01000.
REQ-025 DIV_WAIT with div_done_i: stall_o=0, flush_o=0 in the same cycle; next state RUN.
REQ-026 EXC SHALL last exactly one cycle with redirect_o=1, flush_o=5'b00010, stall_o=0, and all other inputs ignored; next state RUN.
REQ-027 redirect_o and div_abort_o SHALL be 0 in every case not named above.
REQ-028 stall_cnt_o SHALL increment by 1 on each rising edge where stall_o!=0, saturate at 32'hFFFFFFFF, and load 0 when cnt_clr_i=1; cnt_clr_i has priority over increment.
REQ-029 No stall_o bit and flush_o bit for the same stage SHALL be 1 simultaneously.

Reset
REQ-030 While rst_i=1 (asynchronous): state=RUN, stall_cnt_o=0, stall_o=0, flush_o=5'b11111, redirect_o=0, div_abort_o=0.
REQ-031 Reset asserted in MEM_WAIT or DIV_WAIT SHALL abandon the wait without asserting div_abort_o; the first edge after release evaluates in RUN.

Verification
REQ-032 Load-use: ex_rmem_i=1, ex_waddr_i=5, id_rt_i=5 -> stall_o=00011, flush_o=00100, state 0; same stimulus with ex_waddr_i=0 -> stall_o=0, flush_o=0.
REQ-033 Memory wait: dreq_i=1, dack_i=0 for 3 cycles, then dack_i=1 -> stall_o=01111 for 3 cycles, 0 on the ack cycle, stall_cnt_o=3.
REQ-034 Divide abort: div_start_i pulse, then exc_i on the 2nd DIV_WAIT cycle -> div_abort_o=1 for 1 cycle, flush_o=11110, next cycle state=3 with redirect_o=1, then state=0.
REQ-035 Priority: in RUN, exc_i=1, dreq_i=1, dack_i=0, div_start_i=1 together -> EXC path taken (flush_o=11110, next state 3).
REQ-036 Counter: force stall_cnt_o=32'hFFFFFFFE with continuous stall -> reaches FFFFFFFF and holds; cnt_clr_i=1 during stall -> 0.
REQ-037 Async reset mid-DIV_WAIT: rst_i pulse between clock edges -> state_o=0 and flush_o=11111 immediately, div_abort_o stays 0.
